// File: rtl/serial_pkg.sv
// Shared constants for the serial port MMIO window: register offsets,
// STATUS bit positions and the transmit request state encoding.
package serial_pkg;

    localparam logic [3:0] SER_DATA_OFS = 4'h8;
    localparam logic [3:0] SER_STAT_OFS = 4'hC;

    localparam int STAT_TX_READY = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_OVERRUN  = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_BUSY  = 2'd2
    } tx_state_e;

    // STATUS word: zero-extended {overrun, rx_valid, tx_ready}
    function automatic logic [31:0] pack_status(input logic overrun,
                                                input logic rx_valid,
                                                input logic tx_ready);
        logic [31:0] word;
        word                = '0;
        word[STAT_OVERRUN]  = overrun;
        word[STAT_RX_VALID] = rx_valid;
        word[STAT_TX_READY] = tx_ready;
        return word;
    endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Receive byte FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate count. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module serial_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset discards any queued bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until a pointer covers them
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/serial_mmio_responder.sv
// CPU-bus responder for the serial window (DATA at 0x8, STATUS at 0xC).
// Decodes access starts so a held chip-select never repeats a side effect,
// buffers received bytes, and holds the transmit start request until the
// transmitter acknowledges with busy or the hold timer expires.
// Build option: define SERIAL_IRQ_EN to register irq_o = rx_valid | overrun;
// without it irq_o is tied low.
//
// TX request FSM
//   state    | meaning
//   TX_IDLE  | no request outstanding; a DATA write may be accepted
//   TX_START | tx_start_o asserted, waiting for tx_busy_i or hold expiry
//   TX_BUSY  | request released, waiting for the transmitter to finish
module serial_mmio_responder
    import serial_pkg::*;
#(
    parameter int RX_DEPTH   = 16,
    parameter int START_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [7:0]  data_i,
    output logic [31:0] data_o,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_ready_i,
    input  logic        tx_busy_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    output logic        irq_o
);

    localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(START_HOLD - 1);

    logic        prev_ce;
    logic        prev_we;
    logic [3:0]  prev_addr;
    logic        access_start;
    logic        rd_data_acc;
    logic        rd_stat_acc;
    logic        wr_data_acc;

    logic [7:0]  fifo_head;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_pop;
    logic        overflow;
    logic        overrun;
    logic        rx_valid;
    logic        tx_ready;
    logic        wr_accept;
    logic [31:0] read_mux;

    tx_state_e         state;
    tx_state_e         next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_load;
    logic              hold_dec;

    // An access starts on a rising chip-select or when the held access changes target/direction
    assign access_start = ce_i && (!prev_ce || (addr_i != prev_addr) || (we_i != prev_we));
    assign rd_data_acc  = access_start && !we_i && (addr_i == SER_DATA_OFS);
    assign rd_stat_acc  = access_start && !we_i && (addr_i == SER_STAT_OFS);
    assign wr_data_acc  = access_start &&  we_i && (addr_i == SER_DATA_OFS);

    assign rx_valid  = !fifo_empty;
    assign fifo_pop  = rd_data_acc && rx_valid;
    assign overflow  = rx_ready_i && fifo_full && !fifo_pop;
    assign tx_ready  = (state == TX_IDLE) && !tx_busy_i;
    assign wr_accept = wr_data_acc && tx_ready;

    // Remember last cycle's bus request to detect access starts
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ce   <= 1'b0;
            prev_we   <= 1'b0;
            prev_addr <= '0;
        end else begin
            prev_ce   <= ce_i;
            prev_we   <= we_i;
            prev_addr <= addr_i;
        end
    end

    serial_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_ready_i),
        .push_data (rx_data_i),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Sticky overrun; a drop in the same cycle as a STATUS read keeps it set
    always_ff @(posedge clk) begin
        if (rst)              overrun <= 1'b0;
        else if (overflow)    overrun <= 1'b1;
        else if (rd_stat_acc) overrun <= 1'b0;
    end

    // Read data selection; empty DATA reads and unmapped offsets return zero
    always_comb begin
        read_mux = '0;
        case (addr_i)
            SER_DATA_OFS: read_mux = rx_valid ? {24'b0, fifo_head} : 32'b0;
            SER_STAT_OFS: read_mux = pack_status(overrun, rx_valid, tx_ready);
            default:      read_mux = '0;
        endcase
    end

    // Read data captured at access start and held until the next read starts
    always_ff @(posedge clk) begin
        if (rst)                        data_o <= '0;
        else if (access_start && !we_i) data_o <= read_mux;
    end

    // TX FSM next state and hold-timer controls
    always_comb begin
        next_state = state;
        hold_load  = 1'b0;
        hold_dec   = 1'b0;
        case (state)
            TX_IDLE: begin
                if (wr_accept) begin
                    next_state = TX_START;
                    hold_load  = 1'b1;
                end
            end
            TX_START: begin
                if (tx_busy_i || (hold_cnt == '0)) next_state = TX_BUSY;
                else                               hold_dec   = 1'b1;
            end
            TX_BUSY: begin
                if (!tx_busy_i) next_state = TX_IDLE;
            end
            default: next_state = TX_IDLE;
        endcase
    end

    // TX FSM state, hold down-counter and registered request outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TX_IDLE;
            hold_cnt   <= '0;
            tx_start_o <= 1'b0;
            tx_data_o  <= '0;
        end else begin
            state      <= next_state;
            tx_start_o <= (next_state == TX_START);
            if (hold_load)     hold_cnt <= HOLD_LOAD;
            else if (hold_dec) hold_cnt <= hold_cnt - 1'b1;
            if (wr_accept)     tx_data_o <= data_i;
        end
    end

`ifdef SERIAL_IRQ_EN
    // Interrupt follows pending data or overrun with one cycle of lag
    always_ff @(posedge clk) begin
        if (rst) irq_o <= 1'b0;
        else     irq_o <= rx_valid || overrun;
    end
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_mmio_responder.sv
// Bench for serial_mmio_responder: directed scenarios followed by random
// traffic, all outputs compared each cycle with a queue-based reference.
module tb_serial_mmio_responder;

    localparam int RX_DEPTH   = 16;
    localparam int START_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [3:0]  addr_i;
    logic [7:0]  data_i;
    logic [31:0] data_o;
    logic [7:0]  rx_data_i;
    logic        rx_ready_i;
    logic        tx_busy_i;
    logic [7:0]  tx_data_o;
    logic        tx_start_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    serial_mmio_responder #(
        .RX_DEPTH   (RX_DEPTH),
        .START_HOLD (START_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .rx_data_i  (rx_data_i),
        .rx_ready_i (rx_ready_i),
        .tx_busy_i  (tx_busy_i),
        .tx_data_o  (tx_data_o),
        .tx_start_o (tx_start_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    // reference state: queue of bytes, sticky overrun, request phase 0 idle / 1 requesting / 2 waiting
    logic [7:0]  q[$];
    bit          m_ovr;
    bit [31:0]   m_data;
    int          m_phase;
    int          m_left;
    bit [7:0]    m_txd;
    bit          m_irq;
    bit          p_ce;
    bit          p_we;
    bit [3:0]    p_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_cycle();
        bit acc;
        bit ready;
        bit irq_next;
        if (rst) begin
            q.delete();
            m_ovr = 0; m_data = 0; m_phase = 0; m_left = 0; m_txd = 0; m_irq = 0;
            p_ce = 0; p_we = 0; p_addr = 0;
            return;
        end
        acc      = ce_i && (!p_ce || addr_i != p_addr || we_i != p_we);
        ready    = (m_phase == 0) && !tx_busy_i;
        irq_next = (q.size() != 0) || m_ovr;
        if (acc && !we_i) begin
            if (addr_i == 4'h8) begin
                if (q.size() > 0) m_data = {24'b0, q.pop_front()};
                else              m_data = 0;
            end else if (addr_i == 4'hC) begin
                m_data = {29'b0, m_ovr, (q.size() != 0), ready};
                m_ovr  = 0;
            end else begin
                m_data = 0;
            end
        end
        if (rx_ready_i) begin
            if (q.size() < RX_DEPTH) q.push_back(rx_data_i);
            else                     m_ovr = 1;
        end
        case (m_phase)
            0: if (acc && we_i && addr_i == 4'h8 && ready) begin
                   m_phase = 1; m_left = START_HOLD; m_txd = data_i;
               end
            1: if (tx_busy_i || m_left == 1) m_phase = 2;
               else                          m_left--;
            default: if (!tx_busy_i) m_phase = 0;
        endcase
`ifdef SERIAL_IRQ_EN
        m_irq = irq_next;
`else
        m_irq = 0;
`endif
        p_ce = ce_i; p_we = we_i; p_addr = addr_i;
    endfunction

    task automatic step();
        @(posedge clk);
        model_cycle();
        #1;
        check("data_o", data_o, m_data);
        check("tx_start_o", {31'b0, tx_start_o}, {31'b0, (m_phase == 1)});
        check("tx_data_o", {24'b0, tx_data_o}, {24'b0, m_txd});
        check("irq_o", {31'b0, irq_o}, {31'b0, m_irq});
    endtask

    task automatic rd(input logic [3:0] a, input int hold, output logic [31:0] val);
        ce_i = 1; we_i = 0; addr_i = a;
        step();
        val = data_o;
        repeat (hold - 1) step();
        ce_i = 0;
        step();
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        ce_i = 1; we_i = 1; addr_i = a; data_i = d;
        step();
        ce_i = 0;
        step();
    endtask

    task automatic push(input logic [7:0] b);
        rx_ready_i = 1; rx_data_i = b;
        step();
        rx_ready_i = 0;
    endtask

    initial begin
        logic [31:0] v;
        int cnt;
        rst = 1; ce_i = 0; we_i = 0; addr_i = 0; data_i = 0;
        rx_data_i = 0; rx_ready_i = 0; tx_busy_i = 0;
        step(); step();
        check("rst_data_o", data_o, 32'h0);
        check("rst_tx_start", {31'b0, tx_start_o}, 32'h0);
        rst = 0;
        step();

        // two bytes, read back in order
        push(8'h41); push(8'h42);
        rd(4'hC, 1, v); check("t1_stat_rxv", {31'b0, v[1]}, 32'h1);
        rd(4'h8, 1, v); check("t1_rd0", v, 32'h41);
        rd(4'h8, 1, v); check("t1_rd1", v, 32'h42);
        rd(4'hC, 1, v); check("t1_stat_empty", {31'b0, v[1]}, 32'h0);

        // held chip-select pops only once
        push(8'h10); push(8'h11); push(8'h12);
        rd(4'h8, 5, v); check("t2_held", v, 32'h10);
        check("t2_held_end", data_o, 32'h10);
        rd(4'h8, 1, v); check("t2_next", v, 32'h11);
        rd(4'h8, 1, v); check("t2_last", v, 32'h12);
        rd(4'h8, 1, v); check("t2_empty", v, 32'h0);

        // overflow by one byte
        for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
        tx_busy_i = 1;
        rd(4'hC, 1, v); check("t3_stat_ovr", v, 32'h6);
        rd(4'hC, 1, v); check("t3_stat_clr", v, 32'h2);
        tx_busy_i = 0;
        for (int i = 0; i < 16; i++) begin
            rd(4'h8, 1, v); check("t3_drain", v, 32'(8'h80 + i));
        end
        rd(4'h8, 1, v); check("t3_drained", v, 32'h0);

        // start request acknowledged by busy after two cycles
        cnt = 0;
        ce_i = 1; we_i = 1; addr_i = 4'h8; data_i = 8'h55;
        step(); cnt += int'(tx_start_o);
        ce_i = 0;
        step(); cnt += int'(tx_start_o);
        tx_busy_i = 1;
        repeat (3) begin step(); cnt += int'(tx_start_o); end
        check("t4_start_len", cnt, 2);
        check("t4_tx_data", {24'b0, tx_data_o}, 32'h55);
        wr(4'h8, 8'h66);
        check("t4_drop", {24'b0, tx_data_o}, 32'h55);
        tx_busy_i = 0;
        step(); step();
        rd(4'hC, 1, v); check("t4_ready", v, 32'h1);

        // no acknowledge: request times out
        cnt = 0;
        ce_i = 1; we_i = 1; addr_i = 4'h8; data_i = 8'hA5;
        step(); cnt += int'(tx_start_o);
        ce_i = 0;
        repeat (8) begin step(); cnt += int'(tx_start_o); end
        check("t5_start_len", cnt, START_HOLD);
        rd(4'hC, 1, v); check("t5_idle", v, 32'h1);

        // reset while busy with bytes queued
        push(8'h01); push(8'h02); push(8'h03);
        wr(4'h8, 8'h33);
        tx_busy_i = 1;
        step(); step();
        rst = 1;
        step();
        rst = 0;
        check("t6_start_low", {31'b0, tx_start_o}, 32'h0);
        tx_busy_i = 0;
        rd(4'hC, 1, v); check("t6_stat", v, 32'h1);
        check("t6_irq", {31'b0, irq_o}, 32'h0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) begin
                ce_i = 1'($urandom_range(0, 1));
                we_i = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 3))
                    0, 1:    addr_i = 4'h8;
                    2:       addr_i = 4'hC;
                    default: addr_i = 4'($urandom_range(0, 15));
                endcase
            end
            data_i     = 8'($urandom);
            rx_ready_i = ($urandom_range(0, 2) == 0);
            rx_data_i  = 8'($urandom);
            if ($urandom_range(0, 4) == 0) tx_busy_i = ~tx_busy_i;
            step();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
